gpr_file: RTL and testbench
===========================

Name: gpr_file

Overview:
- Slave side of the general-purpose register bus: holds the architectural integer registers.
- Accepts one write per cycle from the write-back stage and serves two combinational read ports to the decode stage.
- Register storage is RAM-inferable, with no reset on the array. Zeroing after reset is done by an internal sequential clear engine.
- Upstream stages stall on o_ready low.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- REG_COUNT, 32, number of registers. Legal values are 16 (RV32E) or 32.
- ADDR_WIDTH, $clog2(REG_COUNT), register address width.

Ports:
- i_clock  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  reset, asynchronous, active-low.
- i_wrAddr  in  ADDR_WIDTH  write register address.
- i_wrData  in  DATA_WIDTH  write data.
- i_wr  in  1  write strobe; already qualified by the valid bit in write-back.
- i_rdAddrA  in  ADDR_WIDTH  read port A address.
- o_rdDataA  out  DATA_WIDTH  read port A data.
- i_rdAddrB  in  ADDR_WIDTH  read port B address.
- o_rdDataB  out  DATA_WIDTH  read port B data.
- o_ready  out  1  clear complete; register file usable.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low, named i_reset, with i_clock as the clock.
- Reset values:
  - State = CLEAR, clear counter = 1, o_ready = 0.
  - o_rdDataA = o_rdDataB = 0, because reads are forced to zero in CLEAR.
  - The array itself is not reset.
- State machine, two states, CLEAR and READY:
  - CLEAR: each cycle, write 0 to array[counter] and increment the counter.
  - When counter == REG_COUNT-1 is written, go to READY on the same edge.
  - CLEAR lasts REG_COUNT-1 cycles after reset deassertion (31 cycles at default).
  - READY: terminal until the next reset. o_ready is registered and rises on the edge that enters READY.
- Writes in CLEAR are ignored; no array update from i_wr.
- Writes in READY: if i_wr=1 and i_wrAddr != 0, array[i_wrAddr] <= i_wrData at the rising edge. Writes to address 0 are discarded.
- Reads are combinational from the array:
  - Address 0 always returns 0.
  - In CLEAR, both ports return 0 regardless of address.
- Address range: with REG_COUNT=16 the address is 4 bits and no out-of-range addresses exist. Upper address bits are not sign-checked.
- Simultaneous events:
  - A read and a write to the same address in the same cycle: result per the optional feature.
  - Both read ports at the same address: both return identical data.
- Reset mid-CLEAR or mid-READY:
  - Immediately returns to CLEAR, counter = 1, o_ready = 0.
  - Any write presented in that cycle is lost.
- Latency: write to readable is 1 cycle, or 0 cycles with bypass. Read latency is 0 cycles, combinational.

Optional Feature:
- Macro: GPR_BYPASS_EN.
- Defined: write-through forwarding.
  - If state is READY, i_wr=1, i_wrAddr != 0 and i_rdAddrX == i_wrAddr, then o_rdDataX = i_wrData in the same cycle, for each port independently.
  - Removes the WB-to-decode hazard.
- Not defined:
  - Read ports return the pre-write array contents during the write cycle; the new value is visible the next cycle.
  - The write-back stage keeps its hazard output meaningful.

Test Plan:
- Reset-clear timing:
  - Stimulus: hold i_reset=0 for 3 cycles, then release.
  - Required: o_ready=0 for exactly 31 rising edges, then 1. After o_ready=1, read x1..x31 on both ports, all 0.
- Basic write/read:
  - Stimulus: in READY, write x5=0xDEADBEEF.
  - Required: next cycle A=x5 returns 0xDEADBEEF and B=x6 returns 0.
- x0 immutability:
  - Stimulus: write x0=0xFFFFFFFF.
  - Required: next cycle both ports reading x0 return 0x00000000.
- Same-cycle write/read:
  - Stimulus: x7 holds 0x11111111; write x7=0x22222222 while A=x7.
  - Required: A=0x22222222 with GPR_BYPASS_EN, 0x11111111 without. Next cycle 0x22222222 in both builds.
- Write during CLEAR:
  - Stimulus: assert i_wr with x3=0x12345678 at cycle 5 after reset release.
  - Required: after o_ready rises, x3 reads 0.
- Reset mid-operation:
  - Stimulus: write x9=0xA5A5A5A5; assert i_reset for 1 cycle mid-CLEAR of a second run.
  - Required: o_ready drops immediately; a fresh 31-cycle clear follows; x9 reads 0.

Source files
------------

// File: rtl/gpr_file.sv
// rtl/gpr_file.sv - integer register file with post-reset sequential clear engine
// Optional write-through forwarding to both read ports: define GPR_BYPASS_EN.
module gpr_file #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_wrAddr,
  input  logic [DATA_WIDTH-1:0] i_wrData,
  input  logic                  i_wr,
  input  logic [ADDR_WIDTH-1:0] i_rdAddrA,
  output logic [DATA_WIDTH-1:0] o_rdDataA,
  input  logic [ADDR_WIDTH-1:0] i_rdAddrB,
  output logic [DATA_WIDTH-1:0] o_rdDataB,
  output logic                  o_ready
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(REG_COUNT - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready_q, ready_d;

  logic [DATA_WIDTH-1:0] mem [REG_COUNT];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic                  fwd_a, fwd_b;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= CLEAR;
      cnt_q   <= ADDR_WIDTH'(1);
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // x0 is never stored: the clear engine starts at 1 and reads of 0 are forced.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    mem_we  = 1'b0;
    mem_wa  = i_wrAddr;
    mem_wd  = i_wrData;
    case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = '0;
        if (cnt_q == LAST_ADDR) begin
          state_d = READY;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      READY: begin
        mem_we = i_wr && (i_wrAddr != '0);
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

`ifdef GPR_BYPASS_EN
  assign fwd_a = i_wr && (i_rdAddrA == i_wrAddr);
  assign fwd_b = i_wr && (i_rdAddrB == i_wrAddr);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  always_comb begin
    o_rdDataA = '0;
    o_rdDataB = '0;
    if (state_q == READY && i_rdAddrA != '0) begin
      o_rdDataA = fwd_a ? i_wrData : mem[i_rdAddrA];
    end
    if (state_q == READY && i_rdAddrB != '0) begin
      o_rdDataB = fwd_b ? i_wrData : mem[i_rdAddrB];
    end
  end

  assign o_ready = ready_q;

endmodule

// File: tb/tb_gpr_file.sv
// tb/tb_gpr_file.sv - directed self-checking bench for gpr_file
// Same-cycle write/read expectation follows GPR_BYPASS_EN.
module tb_gpr_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr;
  logic [4:0]  rd_addr_a;
  logic [31:0] rd_data_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_b;
  logic        ready;

  int passed = 0;
  int total  = 0;
  int edges;

  gpr_file #(.DATA_WIDTH(32), .REG_COUNT(32)) dut (
    .i_clock   (clk),
    .i_reset   (rst_n),
    .i_wrAddr  (wr_addr),
    .i_wrData  (wr_data),
    .i_wr      (wr),
    .i_rdAddrA (rd_addr_a),
    .o_rdDataA (rd_data_a),
    .i_rdAddrB (rd_addr_b),
    .o_rdDataB (rd_data_b),
    .o_ready   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n++;
      if (ready) break;
    end
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = 5'd5; rd_addr_b = 5'd31;

    // Reset state
    @(negedge clk);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_rdA", rd_data_a, 32'd0);
    check("reset_rdB", rd_data_b, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First clear run, with a write attempted at cycle 5
    edges = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 5) begin
        wr = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678; rd_addr_a = 5'd3;
      end
      if (edges == 6) wr = 1'b0;
      if (edges == 10) check("clear_rdA_zero", rd_data_a, 32'd0);
      if (ready) break;
    end
    check("clear1_edges", edges, 32'd31);

    for (int r = 1; r < 32; r++) begin
      rd_addr_a = 5'(r); rd_addr_b = 5'(r); #1;
      check($sformatf("zero_A_x%0d", r), rd_data_a, 32'd0);
      check($sformatf("zero_B_x%0d", r), rd_data_b, 32'd0);
    end

    // Basic write/read
    write_reg(5'd5, 32'hDEADBEEF);
    rd_addr_a = 5'd5; rd_addr_b = 5'd6; #1;
    check("x5_A", rd_data_a, 32'hDEADBEEF);
    check("x6_B", rd_data_b, 32'd0);
    rd_addr_b = 5'd5; #1;
    check("x5_A_same", rd_data_a, 32'hDEADBEEF);
    check("x5_B_same", rd_data_b, 32'hDEADBEEF);

    // x0 immutability
    write_reg(5'd0, 32'hFFFFFFFF);
    rd_addr_a = 5'd0; rd_addr_b = 5'd0; #1;
    check("x0_A", rd_data_a, 32'd0);
    check("x0_B", rd_data_b, 32'd0);

    // Same-cycle write/read
    write_reg(5'd7, 32'h11111111);
    @(negedge clk);
    rd_addr_a = 5'd7; wr = 1'b1; wr_addr = 5'd7; wr_data = 32'h22222222; #1;
`ifdef GPR_BYPASS_EN
    check("x7_samecycle", rd_data_a, 32'h22222222);
`else
    check("x7_samecycle", rd_data_a, 32'h11111111);
`endif
    @(posedge clk); #1;
    wr = 1'b0; #1;
    check("x7_nextcycle", rd_data_a, 32'h22222222);

    // Reset mid-READY, then again mid-CLEAR of the second run
    write_reg(5'd9, 32'hA5A5A5A5);
    rd_addr_a = 5'd9; #1;
    check("x9_written", rd_data_a, 32'hA5A5A5A5);
    @(negedge clk);
    #2 rst_n = 1'b0; #1;
    check("rst_ready_drop", {31'd0, ready}, 32'd0);
    check("rst_rdA_zero", rd_data_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("mid_clear_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(edges);
    check("clear2_edges", edges, 32'd31);
    rd_addr_a = 5'd9; rd_addr_b = 5'd5; #1;
    check("x9_cleared", rd_data_a, 32'd0);
    check("x5_cleared", rd_data_b, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
